// File: rtl/du_rx_loader.sv
// UART byte-stream loader: decodes an instruction count, LSB-first 32-bit
// instruction words with write addresses, and debug-unit mode commands.
module du_rx_loader #(
  parameter int NB_DATA = 32,
  parameter int N_BITS  = 8,
  parameter int N_BYTES = NB_DATA / N_BITS,
  parameter int NB_ADDR = 8
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_rx_done,
  input  logic [N_BITS-1:0]  i_rx_data,
  input  logic               i_mode_enable,
  input  logic               i_reload,
  output logic [N_BITS-1:0]  o_count,
  output logic               o_count_valid,
  output logic [NB_DATA-1:0] o_instruction,
  output logic [NB_ADDR-1:0] o_inst_addr,
  output logic               o_inst_valid,
  output logic               o_load_done,
  output logic [N_BITS-1:0]  o_mode,
  output logic               o_mode_valid,
  output logic               o_mode_drop,
  output logic [2:0]         o_state
);
  localparam logic [2:0] COUNT = 3'b001;
  localparam logic [2:0] LOAD  = 3'b010;
  localparam logic [2:0] MODE  = 3'b100;

  localparam int NB_IDX = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(N_BYTES - 1);

  logic [2:0]                      r_state;
  logic [NB_IDX-1:0]               r_byte_idx;
  logic [NB_ADDR-1:0]              r_loaded;
  logic [N_BYTES-1:0][N_BITS-1:0]  r_word;
  logic [N_BITS-1:0]               r_count;
  logic                            r_count_valid;
  logic [NB_DATA-1:0]              r_instruction;
  logic [NB_ADDR-1:0]              r_inst_addr;
  logic                            r_inst_valid;
  logic                            r_load_done;
  logic [N_BITS-1:0]               r_mode;
  logic                            r_mode_valid;
  logic                            r_mode_drop;

  logic [N_BYTES-1:0][N_BITS-1:0]  w_word;
  logic                            w_word_done;
  logic [NB_ADDR-1:0]              w_loaded_nx;
  logic                            w_last_inst;

  // Each lane takes the incoming byte only when the byte index points at it.
  genvar k;
  generate
    for (k = 0; k < N_BYTES; k++) begin : g_lane
      assign w_word[k] = (r_byte_idx == NB_IDX'(k)) ? i_rx_data : r_word[k];
    end
  endgenerate

  assign w_word_done = (r_byte_idx == LAST_IDX);
  assign w_loaded_nx = r_loaded + 1'b1;
  assign w_last_inst = (w_loaded_nx == NB_ADDR'(r_count));

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state       <= COUNT;
      r_byte_idx    <= '0;
      r_loaded      <= '0;
      r_word        <= '0;
      r_count       <= '0;
      r_count_valid <= 1'b0;
      r_instruction <= '0;
      r_inst_addr   <= '0;
      r_inst_valid  <= 1'b0;
      r_load_done   <= 1'b0;
      r_mode        <= '0;
      r_mode_valid  <= 1'b0;
      r_mode_drop   <= 1'b0;
    end else begin
      r_count_valid <= 1'b0;
      r_inst_valid  <= 1'b0;
      r_mode_valid  <= 1'b0;
      r_mode_drop   <= 1'b0;
      // Reload beats a coincident byte; the byte is simply lost.
      if (i_reload) begin
        r_state     <= COUNT;
        r_byte_idx  <= '0;
        r_loaded    <= '0;
        r_load_done <= 1'b0;
      end else if (i_rx_done) begin
        case (r_state)
          COUNT: begin
            r_count       <= i_rx_data;
            r_count_valid <= 1'b1;
            r_byte_idx    <= '0;
            r_loaded      <= '0;
            r_load_done   <= (i_rx_data == '0);
            r_state       <= (i_rx_data == '0) ? MODE : LOAD;
          end
          LOAD: begin
            r_word     <= w_word;
            r_byte_idx <= w_word_done ? '0 : r_byte_idx + 1'b1;
            if (w_word_done) begin
              r_instruction <= w_word;
              r_inst_addr   <= r_loaded;
              r_inst_valid  <= 1'b1;
              r_loaded      <= w_loaded_nx;
              if (w_last_inst) begin
                r_load_done <= 1'b1;
                r_state     <= MODE;
              end
            end
          end
          MODE: begin
            if (i_mode_enable) begin
              r_mode       <= i_rx_data;
              r_mode_valid <= 1'b1;
            end else begin
              r_mode_drop  <= 1'b1;
            end
          end
          default: r_state <= COUNT;
        endcase
      end
    end
  end

  assign o_count       = r_count;
  assign o_count_valid = r_count_valid;
  assign o_instruction = r_instruction;
  assign o_inst_addr   = r_inst_addr;
  assign o_inst_valid  = r_inst_valid;
  assign o_load_done   = r_load_done;
  assign o_mode        = r_mode;
  assign o_mode_valid  = r_mode_valid;
  assign o_mode_drop   = r_mode_drop;
  assign o_state       = r_state;

endmodule

// File: doc/du_rx_loader.md
# du_rx_loader

Byte-stream loader between the UART receiver and the debug unit. It consumes received bytes (`i_rx_done` / `i_rx_data`) and decodes them into three things: an instruction count, a sequence of 32-bit instructions with their write addresses, and operation-mode commands. The debug unit consumes these as instruction-memory write requests and step/continue commands. The block has its own FSM, so the host protocol does not depend on debug-unit state encoding.

## Interface
Parameters:
- `NB_DATA`, 32: instruction width.
- `N_BITS`, 8: UART byte width.
- `N_BYTES`, 4: bytes per instruction (`NB_DATA/N_BITS`).
- `NB_ADDR`, 8: instruction address width; must be ≥ `N_BITS`.

Ports:
- `i_clock`, in, 1: single clock, rising edge.
- `i_reset`, in, 1: reset, asynchronous, active-low.
- `i_rx_done`, in, 1: one-cycle pulse, byte valid on `i_rx_data`.
- `i_rx_data`, in, `N_BITS`: received byte.
- `i_mode_enable`, in, 1: high while the debug unit can accept a mode command.
- `i_reload`, in, 1: synchronous return to count phase.
- `o_count`, out, `N_BITS`: latched instruction count.
- `o_count_valid`, out, 1: one-cycle pulse when the count is latched.
- `o_instruction`, out, `NB_DATA`: assembled instruction.
- `o_inst_addr`, out, `NB_ADDR`: write address of `o_instruction`.
- `o_inst_valid`, out, 1: one-cycle write strobe.
- `o_load_done`, out, 1: level; all instructions loaded.
- `o_mode`, out, `N_BITS`: last accepted mode byte.
- `o_mode_valid`, out, 1: one-cycle pulse per accepted mode byte.
- `o_mode_drop`, out, 1: one-cycle pulse when a mode byte is discarded.
- `o_state`, out, 3: one-hot FSM state, for debug.

## Operation
- States, one-hot:
  - `COUNT` = 3'b001
  - `LOAD` = 3'b010
  - `MODE` = 3'b100
- Reset (async, `i_reset` = 0):
  - State = `COUNT`.
  - Byte index, instruction counter, and all data outputs = 0.
  - All pulses and `o_load_done` = 0.
- **COUNT:** on `i_rx_done`:
  - `o_count` ← byte; `o_count_valid` pulses.
  - Byte index ← 0; loaded ← 0.
  - Byte = 0 → go to `MODE` and set `o_load_done`.
  - Otherwise → go to `LOAD`.
- **LOAD:** each `i_rx_done` stores the byte at lane k = byte index, bits [8k+7:8k]. Bytes arrive LSB first, which matches the debug unit's transmit ordering.
  - Byte index increments and wraps from `N_BYTES-1` to 0.
  - On the `N_BYTES`-th byte, in the same register update:
    - `o_instruction` ← assembled word.
    - `o_inst_addr` ← loaded count, starting at 0.
    - `o_inst_valid` pulses.
    - loaded increments.
  - If loaded + 1 == `o_count`: `o_load_done` ← 1 and go to `MODE`.
- **MODE:** on `i_rx_done`:
  - `i_mode_enable` = 1 → `o_mode` ← byte and `o_mode_valid` pulses.
  - `i_mode_enable` = 0 → the byte is discarded, `o_mode` is held, and `o_mode_drop` pulses.
  - The state remains `MODE`.
  - The mode value is not interpreted here; the debug unit decodes 4 as step-to-step and 16 as continue.
- **Reload:** `i_reload` = 1 in any state:
  - State ← `COUNT`; byte index, loaded count, and `o_load_done` are cleared.
  - No pulses are issued in that cycle.
  - `o_instruction`, `o_inst_addr`, `o_count`, and `o_mode` hold their values.
- Simultaneous `i_reload` and `i_rx_done`: reload wins and the byte is dropped.
- A partial word left by a reload is discarded and never written.
- Address arithmetic is unsigned `NB_ADDR`-bit. The maximum count of 255 gives addresses 0..254, so there is no wrap.

## Timing
- All outputs are registered.
- Latency: the output update or pulse is visible in the cycle after the `i_rx_done` cycle. It is high for exactly one cycle unless another byte arrives.
- `o_inst_valid` latency is measured from the `i_rx_done` of the final byte of the word.
- `o_load_done` rises in the same cycle as the final `o_inst_valid`, or with `o_count_valid` when the count is 0.
- Back-to-back `i_rx_done` on consecutive cycles must be accepted with no loss. Each byte is processed independently.
- `i_mode_enable` is sampled only in the `i_rx_done` cycle.
- `i_rx_done` held high for several cycles counts as one byte per cycle. The UART guarantees single-cycle pulses.
- Reset deassertion is synchronized by the system; the first accepted byte is the first `i_rx_done` after reset release.

## Test plan
- **Count and load:** send 0x02, then bytes 0x78 0x56 0x34 0x12 and 0xEF 0xBE 0xAD 0xDE.
  - `o_count_valid` pulses with `o_count` = 2.
  - `o_inst_valid` (1): 0x12345678 at address 0.
  - `o_inst_valid` (2): 0xDEADBEEF at address 1.
  - `o_load_done` rises with the second write.
- **Zero count:** send 0x00.
  - No `o_inst_valid`.
  - `o_load_done` = 1 the cycle after the byte; state = `MODE`.
- **Mode gating:**
  - In `MODE`, send 0x04 with `i_mode_enable` = 1 → `o_mode_valid` pulses and `o_mode` = 0x04.
  - Then send 0x10 with `i_mode_enable` = 0 → `o_mode_drop` pulses and `o_mode` stays 0x04.
- **Reload mid-word:**
  - Count = 1; send 2 bytes; assert `i_reload` → no write, state = `COUNT`, `o_load_done` = 0.
  - Then send count 1 and 4 bytes → one write at address 0 containing only the new bytes.
- **Async reset:**
  - Pull `i_reset` low mid-`LOAD`, between clock edges → all outputs are 0 immediately and state = `COUNT`.
  - Back-to-back bytes on 8 consecutive cycles with count 2 → both instructions are written correctly.
